// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: ALU operation codes and the ID/EX control record.
package riscv_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_BGE  = 4'b0101;
  localparam logic [3:0] ALU_BNE  = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_EQ   = 4'b1000;
  localparam logic [3:0] ALU_SLLI = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_SRLI = 4'b1100;
  localparam logic [3:0] ALU_BLT  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b1110;

  // Width-independent control fields of the instruction held in EX.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_ctrl_t;

  // A bubble clears everything; rs1/rs2 = x0 guarantees no bypass can match.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// Operand bypass mux for one source register: EX/MEM beats MEM/WB, x0 never bypassed.
module fwd_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            rs_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  input  logic [4:0]            exm_rd_i,
  input  logic                  exm_reg_write_i,
  input  logic [DATA_WIDTH-1:0] exm_result_i,
  input  logic [4:0]            wb_rd_i,
  input  logic                  wb_reg_write_i,
  input  logic [DATA_WIDTH-1:0] wb_result_i,
  output logic [DATA_WIDTH-1:0] fwd_data_o
);

  always_comb begin
    fwd_data_o = rf_data_i;
    if (exm_reg_write_i && (exm_rd_i != 5'd0) && (exm_rd_i == rs_i)) begin
      fwd_data_o = exm_result_i;
    end else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs_i)) begin
      fwd_data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and operand forwarding.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [4:0]               id_rs1,
  input  logic [4:0]               id_rs2,
  input  logic [4:0]               id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic [4:0]               exm_rd,
  input  logic                     exm_reg_write,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic [4:0]               wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  input  logic                     flush,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    src_a,
  output logic [DATA_WIDTH-1:0]    src_b,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [4:0]               ex_rd,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_store_data
);

  ex_ctrl_t                 ctrl_q, ctrl_d;
  logic [OPCODE_LENGTH-1:0] alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0]    pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]    rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0]    imm_q, imm_d;
  logic                     hazard;
  logic                     load_en;
  logic [DATA_WIDTH-1:0]    rs1_fwd, rs2_fwd;

  // Load in EX whose destination is read by decode; stores read rs2 even with alu_src=1.
  always_comb begin
    hazard = ctrl_q.valid && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) && id_valid &&
             ((ctrl_q.rd == id_rs1) ||
              ((ctrl_q.rd == id_rs2) && (!id_alu_src || id_mem_write)));
    stall   = hazard && !flush;
    load_en = id_valid && !flush && !hazard;
  end

  always_comb begin
    ctrl_d     = EX_CTRL_BUBBLE;
    alu_op_d   = '0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    if (load_en) begin
      ctrl_d.valid     = 1'b1;
      ctrl_d.reg_write = id_reg_write;
      ctrl_d.mem_read  = id_mem_read;
      ctrl_d.mem_write = id_mem_write;
      ctrl_d.alu_src   = id_alu_src;
      ctrl_d.rd        = id_rd;
      ctrl_d.rs1       = id_rs1;
      ctrl_d.rs2       = id_rs2;
      alu_op_d         = id_alu_op;
      pc_d             = id_pc;
      rs1_data_d       = id_rs1_data;
      rs2_data_d       = id_rs2_data;
      imm_d            = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= EX_CTRL_BUBBLE;
      alu_op_q   <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_op_q   <= alu_op_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  fwd_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
    .rs_i            (ctrl_q.rs1),
    .rf_data_i       (rs1_data_q),
    .exm_rd_i        (exm_rd),
    .exm_reg_write_i (exm_reg_write),
    .exm_result_i    (exm_result),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .wb_result_i     (wb_result),
    .fwd_data_o      (rs1_fwd)
  );

  fwd_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
    .rs_i            (ctrl_q.rs2),
    .rf_data_i       (rs2_data_q),
    .exm_rd_i        (exm_rd),
    .exm_reg_write_i (exm_reg_write),
    .exm_result_i    (exm_result),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .wb_result_i     (wb_result),
    .fwd_data_o      (rs2_fwd)
  );

  assign src_a         = rs1_fwd;
  assign src_b         = ctrl_q.alu_src ? imm_q : rs2_fwd;
  assign alu_operation = alu_op_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_rd         = ctrl_q.rd;
  assign ex_pc         = pc_q;
  assign ex_store_data = rs2_fwd;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: datapath width of operands, immediates, PC and results.
REQ-002 Parameter OPCODE_LENGTH, default 4: width of the ALU operation code.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state on rising edge); reset input 1.
REQ-004 Decode inputs: id_valid 1; id_pc, id_rs1_data, id_rs2_data, id_imm DATA_WIDTH; id_rs1, id_rs2, id_rd 5; id_alu_op OPCODE_LENGTH; id_alu_src 1 (1=imm as operand B); id_reg_write, id_mem_read, id_mem_write 1.
REQ-005 Bypass inputs: exm_rd 5, exm_reg_write 1, exm_result DATA_WIDTH (EX/MEM stage); wb_rd 5, wb_reg_write 1, wb_result DATA_WIDTH (MEM/WB stage).
REQ-006 flush input 1: discard the instruction entering this stage (taken branch/jump).
REQ-007 stall output 1: load-use hazard; fetch and decode hold their registers.
REQ-008 ALU-facing outputs: src_a, src_b DATA_WIDTH; alu_operation OPCODE_LENGTH.
REQ-009 Pass-through outputs: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write 1; ex_rd 5; ex_pc DATA_WIDTH; ex_store_data DATA_WIDTH (forwarded rs2).

Function
REQ-010 Each rising clk SHALL load exactly one of: reset image, bubble, or decode fields; priority reset > flush > stall > load.
REQ-011 Bubble SHALL mean valid=0, reg_write=0, mem_read=0, mem_write=0, rd=0, alu_op=4'b0000, all data fields 0.
REQ-012 stall SHALL be combinational: 1 iff ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_alu_src) | (ex_rd==id_rs2 & id_mem_write)).
REQ-013 When stall=1 and flush=0, the next cycle SHALL hold a bubble; decode presents the same instruction again, so hazard clears after exactly one bubble.
REQ-014 flush=1 SHALL force stall=0 and load a bubble, regardless of hazard.
REQ-015 id_valid=0 SHALL load a bubble.
REQ-016 Forwarding (combinational on registered fields), per operand rs1/rs2: if exm_reg_write & exm_rd!=0 & exm_rd==ex_rsN -> exm_result; else if wb_reg_write & wb_rd!=0 & wb_rd==ex_rsN -> wb_result; else registered register-file data.
REQ-017 EX/MEM bypass SHALL take priority over MEM/WB when both match.
REQ-018 Register x0 SHALL never be forwarded; data for rsN=0 passes unchanged from the register file.
REQ-019 src_a SHALL equal forwarded rs1; src_b SHALL equal id_imm (registered) when alu_src=1, else forwarded rs2.
REQ-020 ex_store_data SHALL equal forwarded rs2 independent of alu_src.
REQ-021 Immediate SHALL pass unmodified (no sign or shamt rework); encoding is decode's responsibility.
REQ-022 alu_operation SHALL equal the registered alu_op; latency decode->ALU inputs is exactly one cycle.
REQ-023 Bubble outputs: src_a=src_b=0 unless a bypass matches rs=0 (never), i.e. src_a=src_b=0, alu_operation=4'b0000.

Reset
REQ-024 reset=1 at a rising edge SHALL load the bubble image; stall=0 while registered state is bubble.
REQ-025 Reset mid-stall SHALL clear the hazard; first cycle after reset release loads decode normally.
REQ-026 No output SHALL be X after the first reset edge.

Structure
REQ-027 ALU operation codes (AND 0000, XOR 0001, SUB 0010, OR 0011, ADD 0100, BGE 0101, BNE 0110, SRAI 0111, EQ 1000, SLLI 1001, LUI 1010, SLT 1110, BLT 1101, SRLI 1100) and a bubble-record typedef SHALL live in a shared package riscv_pkg.
REQ-028 Forwarding selection SHALL be one sub-module fwd_unit (pure combinational, instantiated per operand or once for both); hazard logic stays in id_ex_stage.

Verification
REQ-029 Plain load: ADDI rd=5 rs1=1 data1=10 imm=3 alu_src=1 -> next cycle src_a=10, src_b=3, alu_operation=0100.
REQ-030 Bypass priority: ex_rs1=7, exm_rd=7 result=0xAA, wb_rd=7 result=0xBB, both write -> src_a=0xAA; drop exm_reg_write -> 0xBB.
REQ-031 x0: ex_rs1=0, exm_rd=0 reg_write=1 result=0xFF -> src_a=register value 0.
REQ-032 Load-use: LW rd=4 in stage, decode ADD rs2=4 -> stall=1 one cycle, bubble loaded (ex_valid=0), then ADD enters with stall=0.
REQ-033 Flush vs stall: same hazard plus flush=1 -> stall=0, next ex_valid=0, ex_reg_write=0.
REQ-034 Reset mid-stream: reset asserted during valid SUB -> next cycle ex_valid=0, alu_operation=0000, src_a=src_b=0, stall=0.
